// File: rtl/trg_sci_pkt_gen_pkg.sv
// rtl/trg_sci_pkt_gen_pkg.sv - shared constants, FSM encoding and CRC-16 byte step for the science packetiser
// TRG_PKT_TIMESTAMP_EN adds a 4-byte timestamp to every frame.
package trg_sci_pkg;

  localparam logic [15:0] SYNC_WORD      = 16'hEB90;
  localparam logic [15:0] CRC_POLY       = 16'h1021;
  localparam logic [15:0] CRC_INIT       = 16'hFFFF;
  localparam int          FRAME_LEN_BASE = 16;
  localparam int          TS_BYTES       = 4;
  localparam logic [1:0]  MODE_EN_CODE   = 2'b01;

`ifdef TRG_PKT_TIMESTAMP_EN
  localparam int FRAME_LEN = FRAME_LEN_BASE + TS_BYTES;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_CRC_H = 2'd2,
    ST_CRC_L = 2'd3
  } trg_state_e;

  // CRC-16/CCITT, MSB first, one whole byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/trg_sci_pkt_gen_if.sv
// rtl/trg_sci_pkt_gen_if.sv - FIFO read-side bundle between the packetiser and the data-transfer block
interface trg_sci_pkt_gen_if #(
  parameter int FIFO_AW = 8
) ();

  logic               fifo_rd_in;
  logic [7:0]         fifo_data_out;
  logic               fifo_empty_out;
  logic [FIFO_AW:0]   fifo_level_out;

  modport master (
    input  fifo_rd_in,
    output fifo_data_out,
    output fifo_empty_out,
    output fifo_level_out
  );

  modport slave (
    output fifo_rd_in,
    input  fifo_data_out,
    input  fifo_empty_out,
    input  fifo_level_out
  );

endinterface

// File: rtl/trg_sci_byte_fifo.sv
// rtl/trg_sci_byte_fifo.sv - single-clock byte FIFO with registered read data and level output
module trg_sci_byte_fifo #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [7:0]    rd_data_q;
  logic          full, empty, do_wr, do_rd;

  assign full  = level_q[AW];
  assign empty = (level_q == '0);
  assign do_wr = wr_en_i & ~full;
  assign do_rd = rd_en_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at AW bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= 8'h00;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data_o = rd_data_q;
  assign empty_o   = empty;
  assign level_o   = level_q;

endmodule

// File: rtl/trg_sci_pkt_gen.sv
// rtl/trg_sci_pkt_gen.sv - trigger science-data packetiser: framed, sequenced, CRC-protected packets into a byte FIFO
// Optional TRG_PKT_TIMESTAMP_EN: appends a 32-bit cycle-count snapshot before the CRC.
module trg_sci_pkt_gen
  import trg_sci_pkg::*;
#(
  parameter int N_MODES = 6,
  parameter int FIFO_AW = 8,
  parameter int DROP_W  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   data_trans_enb_sig,
  input  logic                   eff_trg_in,
  input  logic [8*N_MODES-1:0]   trg_mode_in,
  input  logic [15:0]            hit_sig_stus_in,
  input  logic [15:0]            eff_trg_cnt_in,
  input  logic [23:0]            trg_busy_time_cnt_in,
  input  logic [7:0]             trg_delay_timer_in,
  trg_sci_pkt_gen_if.master      fifo_if,
  output logic                   frame_busy_out,
  output logic [DROP_W-1:0]      drop_cnt_out
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int PAY_LEN = FRAME_LEN - 2;
  localparam int PAY_W   = 8 * PAY_LEN;
  localparam logic [FIFO_AW:0] ADMIT_MAX = (FIFO_AW + 1)'(DEPTH - FRAME_LEN);
  localparam logic [4:0]       LAST_IDX  = 5'(PAY_LEN - 1);

  trg_state_e        state_q, state_d;
  logic [PAY_W-1:0]  frame_q, frame_d;
  logic [4:0]        idx_q, idx_d;
  logic [15:0]       crc_q, crc_d;
  logic [15:0]       seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [7:0]        grp_oh, grp_mode;
  logic              grp_found;
  logic [PAY_W-1:0]  snap;
  logic              trg_en, space_ok, drop_inc;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic [FIFO_AW:0]  level;

  // Lowest-index enabled group wins
  always_comb begin
    grp_oh    = 8'h00;
    grp_mode  = 8'h00;
    grp_found = 1'b0;
    for (int g = 0; g < N_MODES; g++) begin
      if (!grp_found && (trg_mode_in[8*g+6 +: 2] == MODE_EN_CODE)) begin
        grp_found = 1'b1;
        grp_oh    = 8'(8'h80 >> g);
        grp_mode  = trg_mode_in[8*g +: 8];
      end
    end
  end

`ifdef TRG_PKT_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ts_q <= 32'd0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  assign snap = {SYNC_WORD, seq_q, grp_oh, grp_mode, hit_sig_stus_in, eff_trg_cnt_in,
                 trg_busy_time_cnt_in, trg_delay_timer_in, ts_q};
`else
  assign snap = {SYNC_WORD, seq_q, grp_oh, grp_mode, hit_sig_stus_in, eff_trg_cnt_in,
                 trg_busy_time_cnt_in, trg_delay_timer_in};
`endif

  // Same-cycle reads are ignored so admission is conservative
  assign space_ok = (level <= ADMIT_MAX);
  assign trg_en   = eff_trg_in & data_trans_enb_sig;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    idx_d    = idx_q;
    crc_d    = crc_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    drop_inc = 1'b0;
    wr_en    = 1'b0;
    wr_data  = frame_q[PAY_W-1 -: 8];
    case (state_q)
      ST_IDLE: begin
        if (trg_en) begin
          if (space_ok) begin
            frame_d = snap;
            idx_d   = 5'd0;
            crc_d   = CRC_INIT;
            state_d = ST_EMIT;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        wr_en    = 1'b1;
        drop_inc = trg_en;
        frame_d  = frame_q << 8;
        idx_d    = idx_q + 5'd1;
        // Sync word is outside CRC coverage
        if (idx_q >= 5'd2) begin
          crc_d = crc16_byte(crc_q, wr_data);
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_CRC_H;
        end
      end
      ST_CRC_H: begin
        wr_en    = 1'b1;
        wr_data  = crc_q[15:8];
        drop_inc = trg_en;
        state_d  = ST_CRC_L;
      end
      ST_CRC_L: begin
        wr_en    = 1'b1;
        wr_data  = crc_q[7:0];
        drop_inc = trg_en;
        seq_d    = seq_q + 16'd1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (drop_inc && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      idx_q   <= 5'd0;
      crc_q   <= CRC_INIT;
      seq_q   <= 16'd0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  trg_sci_byte_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i     (clk_in),
    .rst_ni    (rst_in),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (fifo_if.fifo_rd_in),
    .rd_data_o (fifo_if.fifo_data_out),
    .empty_o   (fifo_if.fifo_empty_out),
    .level_o   (level)
  );

  assign fifo_if.fifo_level_out = level;
  assign frame_busy_out         = (state_q != ST_IDLE);
  assign drop_cnt_out           = drop_q;

endmodule

// File: tb/tb_trg_sci_pkt_gen.sv
// tb/tb_trg_sci_pkt_gen.sv - randomized self-checking bench for trg_sci_pkt_gen against a byte-queue reference model
module tb_trg_sci_pkt_gen;
  import trg_sci_pkg::*;

  localparam int N_MODES = 6;
`ifdef TRG_PKT_TIMESTAMP_EN
  localparam int TB_AW = 6;
`else
  localparam int TB_AW = 5;
`endif
  localparam int DEPTH    = 1 << TB_AW;
  localparam int FL       = FRAME_LEN;
  localparam int DROP_W   = 16;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enb = 1'b0;
  logic                 trg = 1'b0;
  logic [8*N_MODES-1:0] mode = '0;
  logic [15:0]          hit = '0;
  logic [15:0]          tcnt = '0;
  logic [23:0]          busyt = '0;
  logic [7:0]           dly = '0;
  logic                 frame_busy;
  logic [DROP_W-1:0]    drop_cnt;

  trg_sci_pkt_gen_if #(.FIFO_AW(TB_AW)) fifo_if ();

  trg_sci_pkt_gen #(
    .N_MODES (N_MODES),
    .FIFO_AW (TB_AW),
    .DROP_W  (DROP_W)
  ) dut (
    .clk_in               (clk),
    .rst_in               (rst_n),
    .data_trans_enb_sig   (enb),
    .eff_trg_in           (trg),
    .trg_mode_in          (mode),
    .hit_sig_stus_in      (hit),
    .eff_trg_cnt_in       (tcnt),
    .trg_busy_time_cnt_in (busyt),
    .trg_delay_timer_in   (dly),
    .fifo_if              (fifo_if),
    .frame_busy_out       (frame_busy),
    .drop_cnt_out         (drop_cnt)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  int          lvl_m, wr_rem, drop_m;
  logic [15:0] seq_m;
  logic [7:0]  dout_m;
  logic [31:0] cyc_m;
  logic [31:0] ts_at_trg;
  logic [7:0]  got [FL];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Bit-serial CRC-16/CCITT reference
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic push_frame();
    logic [7:0]  b[$];
    logic [15:0] c;
    int          sel;
    sel = -1;
    for (int g = 0; g < N_MODES; g++)
      if (sel < 0 && mode[8*g+6 +: 2] == 2'b01) sel = g;
    b = {8'hEB, 8'h90, seq_m[15:8], seq_m[7:0],
         (sel < 0) ? 8'h00 : 8'(8'h80 >> sel),
         (sel < 0) ? 8'h00 : mode[8*sel +: 8],
         hit[15:8], hit[7:0], tcnt[15:8], tcnt[7:0],
         busyt[23:16], busyt[15:8], busyt[7:0], dly};
`ifdef TRG_PKT_TIMESTAMP_EN
    b.push_back(cyc_m[31:24]); b.push_back(cyc_m[23:16]);
    b.push_back(cyc_m[15:8]);  b.push_back(cyc_m[7:0]);
`endif
    c = 16'hFFFF;
    for (int i = 2; i < b.size(); i++) c = crc_upd(c, b[i]);
    b.push_back(c[15:8]);
    b.push_back(c[7:0]);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  // One clock edge of the reference: admission, FIFO occupancy and read data
  task automatic model_step();
    bit rd_eff, wr_now;
    rd_eff = fifo_if.fifo_rd_in && (lvl_m > 0);
    wr_now = (wr_rem > 0);
    if (trg && enb) begin
      if (wr_rem == 0 && (DEPTH - lvl_m) >= FL) begin
        push_frame();
        seq_m++;
        wr_rem = FL;
      end else if (drop_m < DROP_MAX) begin
        drop_m++;
      end
    end
    if (rd_eff) dout_m = exp_q.pop_front();
    if (wr_now) wr_rem--;
    lvl_m = lvl_m + int'(wr_now) - int'(rd_eff);
    cyc_m++;
  endtask

  task automatic check_outs();
    check("level", 32'(fifo_if.fifo_level_out), 32'(lvl_m));
    check("empty", 32'(fifo_if.fifo_empty_out), 32'(lvl_m == 0));
    check("busy",  32'(frame_busy), 32'(wr_rem > 0));
    check("drop",  32'(drop_cnt), 32'(drop_m));
    check("dout",  32'(fifo_if.fifo_data_out), 32'(dout_m));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    trg = 1'b0;
    fifo_if.fifo_rd_in = 1'b0;
    exp_q.delete();
    lvl_m = 0; wr_rem = 0; drop_m = 0; seq_m = 16'd0; dout_m = 8'h00; cyc_m = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic pulse_trg();
    ts_at_trg = cyc_m;
    trg = 1'b1;
    tick();
    trg = 1'b0;
  endtask

  task automatic read_frame();
    fifo_if.fifo_rd_in = 1'b1;
    for (int i = 0; i < FL; i++) begin
      tick();
      got[i] = fifo_if.fifo_data_out;
    end
    fifo_if.fifo_rd_in = 1'b0;
  endtask

  task automatic check_got_crc(input string tag);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 2; i < FL - 2; i++) c = crc_upd(c, got[i]);
    check(tag, {16'h0, got[FL-2], got[FL-1]}, {16'h0, c});
  endtask

  task automatic rand_fields();
    for (int g = 0; g < N_MODES; g++) mode[8*g +: 8] = 8'($urandom);
    hit   = 16'($urandom);
    tcnt  = 16'($urandom);
    busyt = 24'($urandom);
    dly   = 8'($urandom);
  endtask

  initial begin
    int n_fit;
    fifo_if.fifo_rd_in = 1'b0;
    do_reset();
    check("rst_level", 32'(fifo_if.fifo_level_out), 32'd0);
    check("rst_empty", 32'(fifo_if.fifo_empty_out), 32'd1);
    check("rst_dout",  32'(fifo_if.fifo_data_out), 32'd0);
    check("rst_busy",  32'(frame_busy), 32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);

    // Single frame, group 0 = 0x45
    enb = 1'b1;
    mode = '0; mode[7:0] = 8'h45;
    hit = 16'h1234; tcnt = 16'h5678; busyt = 24'h9ABCDE; dly = 8'h3C;
    pulse_trg();
    repeat (FL + 2) tick();
    check("peak_level", 32'(fifo_if.fifo_level_out), 32'(FL));
    read_frame();
    check("f1_sync_h", 32'(got[0]), 32'hEB);
    check("f1_sync_l", 32'(got[1]), 32'h90);
    check("f1_seq_h",  32'(got[2]), 32'h00);
    check("f1_seq_l",  32'(got[3]), 32'h00);
    check("f1_grp",    32'(got[4]), 32'h80);
    check("f1_mode",   32'(got[5]), 32'h45);
    check("f1_delay",  32'(got[13]), 32'h3C);
    check_got_crc("f1_crc");

    // Groups 1 and 3 enabled, group 0 not
    mode = '0; mode[7:0] = 8'h80; mode[15:8] = 8'h41; mode[31:24] = 8'h7F;
    pulse_trg();
    repeat (FL + 1) tick();
    read_frame();
    check("f2_seq_l", 32'(got[3]), 32'h01);
    check("f2_grp",   32'(got[4]), 32'h40);
    check("f2_mode",  32'(got[5]), 32'h41);
    check_got_crc("f2_crc");

    mode = '0; mode[7:0] = 8'hC5; mode[15:8] = 8'h00;
    pulse_trg();
    repeat (FL + 1) tick();
    read_frame();
    check("f3_grp",  32'(got[4]), 32'h00);
    check("f3_mode", 32'(got[5]), 32'h00);

    // FIFO fills, next trigger dropped
    do_reset();
    n_fit = DEPTH / FL;
    for (int k = 0; k <= n_fit; k++) begin
      pulse_trg();
      repeat (FL) tick();
    end
    check("full_drop",  32'(drop_cnt), 32'd1);
    check("full_level", 32'(fifo_if.fifo_level_out), 32'(n_fit * FL));
    fifo_if.fifo_rd_in = 1'b1;
    repeat (DEPTH + 2) tick();
    fifo_if.fifo_rd_in = 1'b0;

    // Retrigger three cycles into a frame
    do_reset();
    pulse_trg();
    tick(); tick();
    pulse_trg();
    repeat (FL) tick();
    check("busy_drop",  32'(drop_cnt), 32'd1);
    check("busy_level", 32'(fifo_if.fifo_level_out), 32'(FL));
    read_frame();
    check("busy_seq_l", 32'(got[3]), 32'h00);
    check_got_crc("busy_crc");

    // 100 back-to-back frames with continuous reads
    do_reset();
    fifo_if.fifo_rd_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      rand_fields();
      pulse_trg();
      repeat (FL) tick();
    end
    repeat (4) tick();
    check("b2b_seq", 32'(seq_m), 32'd100);
    fifo_if.fifo_rd_in = 1'b0;

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rand_fields();
      enb = ($urandom_range(0, 7) != 0);
      trg = ($urandom_range(0, 7) == 0);
      fifo_if.fifo_rd_in = ($urandom_range(0, 1) == 1);
      tick();
    end
    trg = 1'b0;
    enb = 1'b1;
    fifo_if.fifo_rd_in = 1'b1;
    repeat (DEPTH + FL + 4) tick();
    fifo_if.fifo_rd_in = 1'b0;

    // Disabled trigger is ignored entirely
    enb = 1'b0;
    pulse_trg();
    tick();
    check("dis_busy", 32'(frame_busy), 32'd0);
    enb = 1'b1;

    // Reset in the middle of a frame
    pulse_trg();
    repeat (5) tick();
    do_reset();
    check("mid_level", 32'(fifo_if.fifo_level_out), 32'd0);
    check("mid_empty", 32'(fifo_if.fifo_empty_out), 32'd1);
    repeat (3) tick();
    mode = '0; mode[23:16] = 8'h55;
    pulse_trg();
    repeat (FL + 1) tick();
    read_frame();
    check("mid_sync_h", 32'(got[0]), 32'hEB);
    check("mid_sync_l", 32'(got[1]), 32'h90);
    check("mid_seq",    {16'h0, got[2], got[3]}, 32'h0);
    check("mid_grp",    32'(got[4]), 32'h20);
    check_got_crc("mid_crc");
`ifdef TRG_PKT_TIMESTAMP_EN
    check("mid_ts", {got[14], got[15], got[16], got[17]}, ts_at_trg);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
